// File: rtl/register_file_dna_pkg.sv
// Shared types and the byte-merge helper for the multi-port DNA register file.
package register_file_dna_pkg;

    typedef enum logic {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_e;

    // Widest entry the merge helper handles; callers size-cast in and out.
    localparam int RF_MAX_DW = 256;
    localparam int RF_MAX_SW = RF_MAX_DW / 8;

    function automatic logic [RF_MAX_DW-1:0] byte_merge(
        input logic [RF_MAX_DW-1:0] old_d,
        input logic [RF_MAX_DW-1:0] new_d,
        input logic [RF_MAX_SW-1:0] strb
    );
        logic [RF_MAX_DW-1:0] res;
        res = old_d;
        for (int i = 0; i < RF_MAX_SW; i++)
            if (strb[i]) res[8*i +: 8] = new_d[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/register_file_dna_clr_fsm.sv
// Clear engine: walks every entry once after reset or on clr_req, driving zero writes.
module register_file_dna_clr_fsm
    import register_file_dna_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    rf_state_e             state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= RF_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    // clr_req only matters here, so a request while busy is simply lost
                    if (clr_req) begin
                        state   <= RF_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/register_file_dna_mp.sv
// DNA register file: one byte-strobed write port, NUM_RD write-first read ports, hardware clear.
module register_file_dna_mp
    import register_file_dna_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int NUM_RD     = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_en,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH/8-1:0]      w_strb,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [NUM_RD-1:0]            r_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
    input  logic                         clr_req,
    output logic                         busy
);

    localparam bit                    FULL_RANGE = (DEPTH == (1 << ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;

    register_file_dna_clr_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    if (FULL_RANGE) begin : g_w_full
        assign w_in_range = 1'b1;
    end else begin : g_w_part
        assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
    end

    // One merge feeds both the array write and every bypassing read port.
    assign w_old    = mem[w_addr];
    assign w_merged = DATA_WIDTH'(byte_merge(RF_MAX_DW'(w_old), RF_MAX_DW'(w_data),
                                             RF_MAX_SW'(w_strb)));

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (w_en && w_in_range)
            mem[w_addr] <= w_merged;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  r_in_range;
        logic                  hit;
        logic [DATA_WIDTH-1:0] q;

        assign ra  = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = w_en && (w_addr == ra);

        if (FULL_RANGE) begin : g_r_full
            assign r_in_range = 1'b1;
        end else begin : g_r_part
            assign r_in_range = ({1'b0, ra} < DEPTH_X);
        end

        always_ff @(posedge clk) begin
            if (!rst_n)
                q <= '0;
            else if (r_en[k]) begin
                if (busy || !r_in_range) q <= '0;
                else if (hit)            q <= w_merged;
                else                     q <= mem[ra];
            end
        end

        assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = q;
    end

endmodule

// File: tb/tb_register_file_dna_mp.sv
// Directed bench for register_file_dna_mp at DATA_WIDTH=32, DEPTH=100, NUM_RD=2.
module tb_register_file_dna_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 100;
    localparam int NRD   = 2;
    localparam int AW    = 7;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              w_en    = 1'b0;
    logic [AW-1:0]     w_addr  = '0;
    logic [DW/8-1:0]   w_strb  = '0;
    logic [DW-1:0]     w_data  = '0;
    logic [NRD-1:0]    r_en    = '0;
    logic [NRD*AW-1:0] r_addr  = '0;
    logic [NRD*DW-1:0] r_data;
    logic              clr_req = 1'b0;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_file_dna_mp #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_RD     (NRD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (w_en),
        .w_addr  (w_addr),
        .w_strb  (w_strb),
        .w_data  (w_data),
        .r_en    (r_en),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .clr_req (clr_req),
        .busy    (busy)
    );

    // Stimulus tasks start and end on a falling edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        w_en = 1'b1; w_addr = a; w_data = d; w_strb = s;
        @(negedge clk);
        w_en = 1'b0; w_strb = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        r_en = 2'b11; r_addr = {a1, a0};
        @(negedge clk);
        r_en = '0;
        d0 = r_data[DW-1:0];
        d1 = r_data[2*DW-1:DW];
    endtask

    task automatic populate(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), base + DW'(i), 4'hF);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d0, d1;
        int cnt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_tests++;
        if (r_data !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", r_data); end
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
        n_tests++;
        if (cnt != 100) begin n_fail++; $display("FAIL reset_busy_len: got %0d expected 100", cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(DEPTH - 1 - i), d0, d1);
            n_tests++;
            if (d0 !== '0 || d1 !== '0) begin
                n_fail++;
                $display("FAIL reset_zero[%0d]: got %h/%h expected 0/0", i, d0, d1);
            end
        end
    endtask

    task automatic test_strobes();
        logic [DW-1:0] d0, d1;
        do_write(7'd5, 32'hDEADBEEF, 4'hF);
        do_write(7'd5, 32'h11223344, 4'b0101);
        do_read(7'd5, 7'd5, d0, d1);
        n_tests++;
        if (d0 !== 32'hDE22BE44 || d1 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL strobe_merge: got %h/%h expected DE22BE44", d0, d1);
        end
        do_write(7'd5, 32'hFFFFFFFF, 4'h0);
        do_read(7'd5, 7'd5, d0, d1);
        n_tests++;
        if (d0 !== 32'hDE22BE44) begin
            n_fail++; $display("FAIL strobe_zero: got %h expected DE22BE44", d0);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d0, d1;
        do_write(7'd7, 32'hAAAAAAAA, 4'hF);
        w_en = 1'b1; w_addr = 7'd7; w_data = 32'h0000FFFF; w_strb = 4'b0011;
        r_en = 2'b11; r_addr = {7'd7, 7'd7};
        @(negedge clk);
        w_en = 1'b0; w_strb = '0; r_en = '0;
        n_tests++;
        if (r_data[DW-1:0] !== 32'hAAAAFFFF || r_data[2*DW-1:DW] !== 32'hAAAAFFFF) begin
            n_fail++; $display("FAIL bypass: got %h expected AAAAFFFF on both ports", r_data);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (r_data[DW-1:0] !== 32'hAAAAFFFF) begin
            n_fail++; $display("FAIL read_hold: got %h expected AAAAFFFF", r_data[DW-1:0]);
        end
        do_read(7'd5, 7'd7, d0, d1);
        n_tests++;
        if (d0 !== 32'hDE22BE44 || d1 !== 32'hAAAAFFFF) begin
            n_fail++; $display("FAIL split_ports: got %h/%h expected DE22BE44/AAAAFFFF", d0, d1);
        end
    endtask

    task automatic test_clr();
        logic [DW-1:0] d0, d1;
        int cnt;
        populate(32'hC0DE0000);
        do_read(7'd99, 7'd10, d0, d1);
        n_tests++;
        if (d0 !== 32'hC0DE0063 || d1 !== 32'hC0DE000A) begin
            n_fail++; $display("FAIL populate: got %h/%h expected C0DE0063/C0DE000A", d0, d1);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            cnt++;
            clr_req = (cnt == 50);
            w_en = 1'b1; w_addr = 7'd3; w_data = 32'hFFFFFFFF; w_strb = 4'hF;
            r_en = 2'b11; r_addr = {7'd10, 7'd10};
            @(negedge clk);
        end
        clr_req = 1'b0; w_en = 1'b0; w_strb = '0; r_en = '0;
        n_tests++;
        if (cnt != 100) begin n_fail++; $display("FAIL clr_busy_len: got %0d expected 100", cnt); end
        n_tests++;
        if (r_data !== '0) begin n_fail++; $display("FAIL busy_read: got %h expected 0", r_data); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_no_restart: got %b expected 0", busy); end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(i), d0, d1);
            n_tests++;
            if (d0 !== '0 || d1 !== '0) begin
                n_fail++; $display("FAIL clr_zero[%0d]: got %h/%h expected 0/0", i, d0, d1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [DW-1:0] d0, d1;
        int cnt;
        populate(32'h5A5A0000);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
        n_tests++;
        if (cnt != 100) begin n_fail++; $display("FAIL midclr_busy_len: got %0d expected 100", cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(i), d0, d1);
            n_tests++;
            if (d0 !== '0 || d1 !== '0) begin
                n_fail++; $display("FAIL midclr_zero[%0d]: got %h/%h expected 0/0", i, d0, d1);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d0, d1;
        populate(32'h77000000);
        do_write(7'd120, 32'h12345678, 4'hF);
        do_read(7'd120, 7'd120, d0, d1);
        n_tests++;
        if (d0 !== '0 || d1 !== '0) begin
            n_fail++; $display("FAIL oob_read: got %h/%h expected 0/0", d0, d1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(i), d0, d1);
            n_tests++;
            if (d0 !== 32'h77000000 + DW'(i)) begin
                n_fail++; $display("FAIL oob_keep[%0d]: got %h expected %h", i, d0, 32'h77000000 + DW'(i));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_strobes();
        test_bypass();
        test_clr();
        test_reset_mid_clear();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
